// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared encodings for the sized data memory.
// Holds the RISC-V load/store funct3 codes, the access-size and fault-code
// enums, and the size-to-byte-count helper.
package dmem_pkg;

  // RISC-V load/store funct3 encodings (bit 2 = zero-extend for loads)
  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  // Access size, taken straight from funct3[1:0]
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Response fault code as seen on rsp_fault
  typedef enum logic [1:0] {
    FLT_OK       = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_RANGE    = 2'b10,
    FLT_ILLEGAL  = 2'b11
  } fault_e;

  // Number of bytes touched by an access of the given size
  function automatic logic [3:0] size_bytes(input size_e sz);
    case (sz)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// dmem_align -- combinational byte-lane unit for the sized data memory.
// Store side: builds the byte-enable mask and moves right-aligned store data
// into its lane. Load side: pulls the addressed bytes out of a word and
// sign- or zero-extends them to XLEN.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [$clog2(XLEN/8)-1:0] st_lane,
  input  size_e                     st_size,
  input  logic [XLEN-1:0]           st_data,
  output logic [XLEN/8-1:0]         be,
  output logic [XLEN-1:0]           st_shifted,
  input  logic [$clog2(XLEN/8)-1:0] ld_lane,
  input  size_e                     ld_size,
  input  logic                      ld_unsigned,
  input  logic [XLEN-1:0]           ld_word,
  output logic [XLEN-1:0]           ld_result
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   be_base;
  logic [3:0]      st_bytes;
  logic [XLEN-1:0] ld_shifted;

  // Store path: contiguous mask of st_bytes ones, then shift both mask and data to the lane
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    be_base  = '0;
    st_bytes = size_bytes(st_size);
    for (int b = 0; b < NB; b++) begin
      be_base[b] = (b < int'(st_bytes));
    end
    be         = be_base << st_lane;
    st_shifted = st_data << {st_lane, 3'b000};
  end

  // Load path: bring the addressed lane down to bit 0, then extend by size and signedness
  always_comb begin
    ld_shifted = ld_word >> {ld_lane, 3'b000};
    ld_result  = ld_shifted;
    case (ld_size)
      SZ_B: ld_result = ld_unsigned ? XLEN'(ld_shifted[7:0])  : XLEN'($signed(ld_shifted[7:0]));
      SZ_H: ld_result = ld_unsigned ? XLEN'(ld_shifted[15:0]) : XLEN'($signed(ld_shifted[15:0]));
      SZ_W: ld_result = ld_unsigned ? XLEN'(ld_shifted[31:0]) : XLEN'($signed(ld_shifted[31:0]));
      default: ld_result = ld_shifted;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// dmem_sized -- single-port data memory with RISC-V sized loads/stores.
// One request per cycle, no back-pressure; the response appears exactly one
// cycle after an accepted request. Faults (illegal > out-of-range >
// misaligned) suppress the write and force rsp_rdata to zero.
// Optional macro DMEM_FWD_EN: stores go through a one-entry write buffer
// committed on the following edge, and loads merge that buffer bytewise over
// a read-first array read. Without it the array is a write-first RAM.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [1:0]      rsp_fault
);

  localparam int NB     = XLEN / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [LANE_W-1:0] lane;
  logic [IDX_W-1:0]  idx;
  size_e             size;
  logic [3:0]        nbytes;
  logic              illegal;
  logic              out_of_range;
  logic              misaligned;
  fault_e            fault;
  logic              accept;
  logic              do_write;

  logic [NB-1:0]     be;
  logic [XLEN-1:0]   st_shifted;
  logic [XLEN-1:0]   ld_result;

  logic [XLEN-1:0]   mem [DEPTH];
  logic [XLEN-1:0]   rd_next;
  logic [XLEN-1:0]   rd_word;

  fault_e            fault_q;
  logic              ld_ok_q;
  size_e             ld_size_q;
  logic              ld_uns_q;
  logic [LANE_W-1:0] ld_lane_q;

  assign lane = req_addr[LANE_W-1:0];
  assign idx  = req_addr[LANE_W +: IDX_W];

  // Request decode: size, fault classification with priority, write qualification
  always_comb begin
    size         = size_e'(req_funct3[1:0]);
    nbytes       = size_bytes(size);
    illegal      = (req_funct3 == F3_BAD) || (req_we && req_funct3[2]) ||
                   ((XLEN == 32) && ((req_funct3 == F3_D) || (req_funct3 == F3_WU)));
    // DEPTH*NB is a power of two, so any set bit above the word index is out of range
    out_of_range = |req_addr[AW-1:LANE_W+IDX_W];
    misaligned   = |(lane & LANE_W'(nbytes - 4'd1));
    if (illegal)           fault = FLT_ILLEGAL;
    else if (out_of_range) fault = FLT_RANGE;
    else if (misaligned)   fault = FLT_MISALIGN;
    else                   fault = FLT_OK;
    accept   = req_valid && !rst;
    do_write = accept && req_we && (fault == FLT_OK);
  end

  dmem_align #(.XLEN(XLEN)) u_align (
    .st_lane     (lane),
    .st_size     (size),
    .st_data     (req_wdata),
    .be          (be),
    .st_shifted  (st_shifted),
    .ld_lane     (ld_lane_q),
    .ld_size     (ld_size_q),
    .ld_unsigned (ld_uns_q),
    .ld_word     (rd_word),
    .ld_result   (ld_result)
  );

`ifdef DMEM_FWD_EN
  logic             wb_valid;
  logic [IDX_W-1:0] wb_idx;
  logic [NB-1:0]    wb_mask;
  logic [XLEN-1:0]  wb_data;

  // Commit the buffered store one edge late; this keeps running through reset so no accepted store is lost
  always_ff @(posedge clk) begin
    if (wb_valid) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_mask[b]) mem[wb_idx][8*b +: 8] <= wb_data[8*b +: 8];
      end
    end
  end

  // Capture each accepted store into the one-entry write buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= do_write;
    end
    if (do_write) begin
      wb_idx  <= idx;
      wb_mask <= be;
      wb_data <= st_shifted;
    end
  end

  // Read-first array data overlaid bytewise with a pending store to the same word
  always_comb begin
    rd_next = mem[idx];
    if (wb_valid && (wb_idx == idx)) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_mask[b]) rd_next[8*b +: 8] = wb_data[8*b +: 8];
      end
    end
  end
`else
  // Write-first array: the store lands on this edge and is visible to the next cycle's load
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; its contents are undefined at power-up and survive rst.
    if (do_write) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= st_shifted[8*b +: 8];
      end
    end
  end

  // Array read for the load being accepted this cycle
  always_comb begin
    rd_next = mem[idx];
  end
`endif

  // Response control: one-cycle latency, cleared and dropped while rst is high
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      rsp_valid <= 1'b0;
      fault_q   <= FLT_OK;
      ld_ok_q   <= 1'b0;
    end else begin
      rsp_valid <= req_valid;
      fault_q   <= req_valid ? fault : FLT_OK;
      ld_ok_q   <= req_valid && !req_we && (fault == FLT_OK);
    end
  end

  // Load datapath capture; qualified downstream by ld_ok_q, so it needs no reset
  always_ff @(posedge clk) begin
    if (accept && !req_we) begin
      rd_word   <= rd_next;
      ld_size_q <= size;
      ld_uns_q  <= req_funct3[2];
      ld_lane_q <= lane;
    end
  end

  assign rsp_fault = fault_q;
  assign rsp_rdata = ld_ok_q ? ld_result : '0;

endmodule

// File: doc/dmem_sized.md
DMEM_SIZED -- requirements
Module: dmem_sized

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the data width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter DEPTH, default 1024, giving the number of XLEN-bit words; it SHALL be a power of two.
REQ-003 The block SHALL have parameter AW, default 64, giving the byte-address width.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, width 1: request present this cycle.
REQ-007 The block SHALL have port req_we, input, width 1: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_funct3, input, width 3: RISC-V load/store funct3 (size plus unsigned bit).
REQ-009 The block SHALL have port req_addr, input, width AW: byte address.
REQ-010 The block SHALL have port req_wdata, input, width XLEN: store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, width 1: response for the previous-cycle request.
REQ-012 The block SHALL have port rsp_rdata, output, width XLEN: load result, extended to XLEN.
REQ-013 The block SHALL have port rsp_fault, output, width 2: 00 ok, 01 misaligned, 10 out-of-range, 11 illegal funct3.

Function
REQ-014 Requests SHALL always be accepted; there is no back-pressure.
REQ-015 The word index SHALL be req_addr[log2(XLEN/8) +: log2(DEPTH)], and the byte lane SHALL be the low log2(XLEN/8) bits.
REQ-016 Every accepted request SHALL produce exactly one response with rsp_valid=1 one cycle later, and rsp_valid SHALL be 0 in every other cycle.
REQ-017 Loads SHALL use funct3 000/001/010/011 for sign-extended byte/half/word/double, and 100/101/110 for zero-extended byte/half/word.
REQ-018 Stores SHALL use funct3 000/001/010/011 for byte/half/word/double, and SHALL write only the addressed bytes.
REQ-019 Priority of faults SHALL be illegal > out-of-range > misaligned.
REQ-020 funct3 SHALL be illegal when it is 111, when it is 011 with XLEN=32, when it is 110 with XLEN=32, or when a store has funct3[2]=1.
REQ-021 Out-of-range SHALL mean req_addr >= DEPTH*XLEN/8.
REQ-022 Misaligned SHALL mean req_addr is not a multiple of the access size; accesses never straddle words.
REQ-023 A faulting request SHALL leave memory unmodified and SHALL return rsp_rdata=0 with the fault code.
REQ-024 A store response SHALL have rsp_rdata=0.
REQ-025 A store followed in the next cycle by a load of the same bytes SHALL return the new data.
REQ-026 For a same-cycle load and store to the same word, behaviour SHALL be as set in Configuration (only via back-to-back requests; one request per cycle).
REQ-027 Memory contents SHALL be undefined at power-up; no file I/O SHALL be performed in synthesised logic.

Reset
REQ-028 While rst=1, rsp_valid, rsp_rdata and rsp_fault SHALL be 0 on the next edge.
REQ-029 A request presented while rst=1 SHALL be dropped, with no write and no response.
REQ-030 Memory contents SHALL be retained across reset.
REQ-031 A response pending when rst rises SHALL be discarded.

Configuration
REQ-032 With DMEM_FWD_EN defined, a load issued in the cycle after a store to the same word SHALL be served from a one-entry write buffer (address, byte mask, data), merged bytewise with the array read, so the RAM can be a pure read-first macro.
REQ-033 Without DMEM_FWD_EN, the array SHALL be write-first behavioural RAM, with identical externally visible results.
REQ-034 In both configurations, latency and fault behaviour SHALL be identical.

Structure
REQ-035 Package dmem_pkg SHALL hold the funct3 encoding constants, the size enum (B/H/W/D), the fault-code enum and the helper size-to-bytes function.
REQ-036 The design SHALL have one sub-module, dmem_align, a combinational unit producing the byte-enable mask and shifted store data, and extracting and extending load data.

Verification
REQ-037 Bench SHALL check: sd 0x1122334455667788 to addr 0x10, then ld 0x10 -> rsp_valid next cycle, rdata 0x1122334455667788, fault 00.
REQ-038 Bench SHALL check: sb 0x80 to 0x13, then lb 0x13 -> 0xFFFFFFFFFFFFFF80; lbu 0x13 -> 0x80; ld 0x10 -> 0x1122334480667788.
REQ-039 Bench SHALL check: lw 0x12 -> fault 01, rdata 0; sh 0x11 -> fault 01, a following ld 0x10 unchanged.
REQ-040 Bench SHALL check: ld 0x2000 (DEPTH=1024, XLEN=64) -> fault 10; funct3 111 -> fault 11; sw with funct3 110 -> fault 11.
REQ-041 Bench SHALL check: back-to-back sw 0xDEADBEEF to 0x20, then lwu 0x20 in the next cycle -> 0x00000000DEADBEEF, with and without DMEM_FWD_EN.
REQ-042 Bench SHALL check: a request in the same cycle as rst=1 -> no response and no write; a pending response killed by reset -> rsp_valid 0; earlier data still readable after reset.
